// File: rtl/dskw_pkg.sv
// Shared types and constants for the deskew job sequencer.
package dskw_pkg;

  localparam int unsigned IMG_SIZE  = 784;
  localparam int unsigned OUT_BASE  = 784;
  localparam int unsigned IMG_LAST  = IMG_SIZE - 1;
  localparam int unsigned CNT_WIDTH = 10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitLow,
    StWaitHigh,
    StDrain
  } state_e;

endpackage

// File: rtl/deskew_sequencer_if.sv
// Stream, BRAM port A and Deskew control signals of the deskew sequencer.
interface deskew_sequencer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 11
);

  logic                  s_valid;
  logic                  s_ready;
  logic [WIDTH-1:0]      s_data;

  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;

  logic                  dskw_start;
  logic                  dskw_ready;

  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [WIDTH-1:0]      bram_wdata;
  logic [WIDTH-1:0]      bram_rdata;

  // master: the sequencer; slave: the surrounding system (host, BRAM, Deskew)
  modport master (
    input  s_valid, s_data, m_ready, dskw_ready, bram_rdata,
    output s_ready, m_valid, m_data, m_last, dskw_start,
           bram_en, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    output s_valid, s_data, m_ready, dskw_ready, bram_rdata,
    input  s_ready, m_valid, m_data, m_last, dskw_start,
           bram_en, bram_we, bram_addr, bram_wdata
  );

endinterface

// File: rtl/dskw_skid_buffer.sv
// Two-entry output FIFO that absorbs the BRAM read latency; reports free slots
// including a slot being vacated by a pop in the current cycle.
module dskw_skid_buffer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       free_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o && ready_i;
  assign free_o  = 2'd2 - count_q + {1'b0, pop};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/deskew_sequencer.sv
// Runs one deskew job: load image into BRAM, kick Deskew, wait, drain the result.
// Optional wait-state watchdog with sticky timeout_err: define DSKW_TIMEOUT_EN.
module deskew_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned IMG_SIZE   = dskw_pkg::IMG_SIZE,
  parameter int unsigned OUT_BASE   = dskw_pkg::OUT_BASE
`ifdef DSKW_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 200000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  deskew_sequencer_if.master  bus,
  output logic                busy,
  output logic                img_done
`ifdef DSKW_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  import dskw_pkg::*;

  localparam logic [CNT_WIDTH-1:0]  CntLast = CNT_WIDTH'(IMG_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] OutBase = ADDR_WIDTH'(OUT_BASE);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 rd_all_q, rd_all_d;
  logic                 inflight_q, inflight_d;

  logic                 buf_valid;
  logic [WIDTH-1:0]     buf_data;
  logic [1:0]           buf_free;
  logic                 pop;

  dskw_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (bus.bram_rdata),
    .valid_o (buf_valid),
    .ready_i (bus.m_ready),
    .data_o  (buf_data),
    .free_o  (buf_free)
  );

  assign bus.m_valid = buf_valid;
  assign bus.m_data  = buf_data;
  assign pop         = buf_valid && bus.m_ready;

`ifdef DSKW_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

  logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               waiting;
  logic               wd_expire;

  assign waiting     = (state_q == StWaitLow) || (state_q == StWaitHigh);
  assign wd_expire   = waiting && (wd_cnt_q == WdLast);
  assign timeout_err = timeout_err_q;

  always_comb begin
    wd_cnt_d      = '0;
    timeout_err_d = timeout_err_q || wd_expire;
    if (waiting && !wd_expire) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    out_cnt_d      = out_cnt_q;
    rd_all_d       = rd_all_q;
    inflight_d     = 1'b0;
    bus.s_ready    = 1'b0;
    bus.dskw_start = 1'b0;
    bus.bram_en    = 1'b0;
    bus.bram_we    = 1'b0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    img_done       = 1'b0;
    busy           = (state_q != StIdle);
    bus.m_last     = buf_valid && (out_cnt_q == CntLast);

    case (state_q)
      StIdle: begin
        // The beat that wakes us is left on the bus and taken in LOAD.
        if (bus.s_valid) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.bram_en    = 1'b1;
          bus.bram_we    = 1'b1;
          bus.bram_addr  = ADDR_WIDTH'(wr_cnt_q);
          bus.bram_wdata = bus.s_data;
          if (wr_cnt_q == CntLast) begin
            wr_cnt_d = '0;
            state_d  = StStart;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        bus.dskw_start = 1'b1;
        state_d        = StWaitLow;
      end
      StWaitLow: begin
        // A ready still high from the previous job must be seen to fall first.
        if (!bus.dskw_ready) begin
          state_d = StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (bus.dskw_ready) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!rd_all_q && (buf_free > {1'b0, inflight_q})) begin
          inflight_d    = 1'b1;
          bus.bram_en   = 1'b1;
          bus.bram_addr = OutBase + ADDR_WIDTH'(rd_cnt_q);
          if (rd_cnt_q == CntLast) begin
            rd_all_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        if (pop) begin
          if (out_cnt_q == CntLast) begin
            img_done  = 1'b1;
            state_d   = StIdle;
            out_cnt_d = '0;
            rd_cnt_d  = '0;
            rd_all_d  = 1'b0;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef DSKW_TIMEOUT_EN
    if (wd_expire) begin
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rd_all_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_all_q   <= rd_all_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_deskew_sequencer.sv
// Directed bench for deskew_sequencer with a BRAM model and a behavioural Deskew
// model that writes out[i] = 3*in[i] + 0x100. Build with DSKW_TIMEOUT_EN for the watchdog case.
module tb_deskew_sequencer;
  import dskw_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 11;
  localparam int          N  = 784;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic img_done;
`ifdef DSKW_TIMEOUT_EN
  logic timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  deskew_sequencer_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  deskew_sequencer #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .IMG_SIZE   (N),
    .OUT_BASE   (N)
`ifdef DSKW_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .img_done (img_done)
`ifdef DSKW_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  function automatic logic [15:0] pix(input int img, input int i);
    return 16'(i + img * 'h1111);
  endfunction

  function automatic logic [15:0] expd(input int img, input int i);
    return 16'(pix(img, i) * 3 + 'h100);
  endfunction

  // BRAM (port A from DUT) plus Deskew model (port B modelled as direct array access)
  logic [15:0] mem [2048];
  int ds_state = 0;
  int ds_cnt   = 0;
  int ds_drop  = 0;
  int ds_len   = 1000;

  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
      bus.bram_rdata <= mem[bus.bram_addr];
    end
    if (reset) begin
      ds_state       <= 0;
      bus.dskw_ready <= 1'b1;
    end else begin
      case (ds_state)
        0: if (bus.dskw_start) begin ds_state <= 1; ds_cnt <= 0; end
        1: if (ds_cnt >= ds_drop) begin
             bus.dskw_ready <= 1'b0; ds_state <= 2; ds_cnt <= 0;
           end else ds_cnt <= ds_cnt + 1;
        2: if (ds_cnt >= ds_len) begin
             bus.dskw_ready <= 1'b1; ds_state <= 0;
             for (int i = 0; i < N; i++) mem[N + i] <= 16'(mem[i] * 3 + 'h100);
           end else ds_cnt <= ds_cnt + 1;
        default: ds_state <= 0;
      endcase
    end
  end

  // Monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] got_q [$];
  bit          last_q [$];
  int done_cnt = 0, start_cnt = 0, wr_total = 0, wr_err = 0, stall_err = 0, valid_cyc = 0;
  int last_wr_cyc = 0, start_cyc = 0, rise_cyc = 0, first_v_cyc = 0, done_cyc = 0, err_cyc = 0;
  int exp_addr = 0;
  logic prev_rdy = 1'b1, prev_v = 1'b0, prev_stall = 1'b0, prev_l = 1'b0, prev_err = 1'b0;
  logic [15:0] prev_d = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      prev_v     <= 1'b0;
      prev_rdy   <= 1'b1;
      exp_addr   <= 0;
    end else begin
      if (bus.bram_en && bus.bram_we) begin
        wr_total    <= wr_total + 1;
        last_wr_cyc <= cyc;
        exp_addr    <= (exp_addr == N - 1) ? 0 : exp_addr + 1;
        if (bus.bram_addr != 11'(exp_addr) || !bus.s_valid || !bus.s_ready) wr_err <= wr_err + 1;
      end
      if (bus.dskw_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
      if (bus.dskw_ready && !prev_rdy) rise_cyc <= cyc;
      prev_rdy <= bus.dskw_ready;
      if (bus.m_valid && !prev_v) first_v_cyc <= cyc;
      if (bus.m_valid) valid_cyc <= valid_cyc + 1;
      prev_v <= bus.m_valid;
      if (prev_stall && !(bus.m_valid && bus.m_data === prev_d && bus.m_last === prev_l))
        stall_err <= stall_err + 1;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        last_q.push_back(bus.m_last);
      end
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_d     <= bus.m_data;
      prev_l     <= bus.m_last;
      if (img_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
`ifdef DSKW_TIMEOUT_EN
      if (timeout_err && !prev_err) err_cyc <= cyc;
      prev_err <= timeout_err;
`endif
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_image(input int img, input int duty, input int count);
    int  i = 0;
    int  g = 0;
    bit  hs;
    while (i < count && g < 20000) begin
      bus.s_valid = ($urandom_range(99) < duty);
      bus.s_data  = pix(img, i);
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      tick();
      if (hs) i++;
      g++;
    end
    bus.s_valid = 1'b0;
    check("send beats", i, count);
  endtask

  task automatic wait_done(input bit bp, input int base_done);
    int n = 0;
    while (done_cnt == base_done && n < 6000) begin
      bus.m_ready = bp ? 1'($urandom_range(1)) : 1'b1;
      tick();
      n++;
    end
    bus.m_ready = 1'b1;
    check("done in budget", n < 6000, 1);
  endtask

  task automatic check_image(input string tag, input int img, input int base);
    int errs = 0, lasts = 0, lastpos = -1;
    check({tag, " count"}, got_q.size() - base, N);
    if (got_q.size() >= base + N) begin
      for (int i = 0; i < N; i++) begin
        if (got_q[base + i] !== expd(img, i)) errs++;
        if (last_q[base + i]) begin lasts++; lastpos = i; end
      end
    end
    check({tag, " data"}, errs, 0);
    check({tag, " last cnt"}, lasts, 1);
    check({tag, " last pos"}, lastpos, N - 1);
  endtask

  int b_got, b_done, b_start, b_wr, b_stall, b_valid;

  task automatic snap();
    b_got = got_q.size(); b_done = done_cnt; b_start = start_cnt;
    b_wr = wr_total; b_stall = stall_err; b_valid = valid_cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst busy", busy, 0);
    check("rst s_ready", bus.s_ready, 0);
    check("rst m_valid", bus.m_valid, 0);
    check("rst m_data", bus.m_data, 0);
    check("rst m_last", bus.m_last, 0);
    check("rst start", bus.dskw_start, 0);
    check("rst bram_en", bus.bram_en, 0);
    check("rst bram_we", bus.bram_we, 0);
    check("rst bram_addr", bus.bram_addr, 0);
    check("rst img_done", img_done, 0);
`ifdef DSKW_TIMEOUT_EN
    check("rst timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    tick();

    // 1: single image, value = index, no stalls
    snap();
    ds_drop = 0; ds_len = 1000;
    send_image(0, 100, N);
    wait_done(1'b0, b_done);
    check("t1 writes", wr_total - b_wr, N);
    check("t1 wr order", wr_err, 0);
    check("t1 starts", start_cnt - b_start, 1);
    check("t1 start after last", start_cyc - last_wr_cyc, 1);
    check("t1 done pulses", done_cnt - b_done, 1);
    check("t1 first pixel", got_q[b_got], 16'h0100);
    check("t1 last pixel", got_q[b_got + N - 1], 16'd2605);
    check_image("t1", 0, b_got);
    check("t1 first valid lat", first_v_cyc - rise_cyc, 3);
    check("t1 done lat", done_cyc - rise_cyc, N + 2);
    check("t1 idle busy", busy, 0);

    // 2: random backpressure
    snap();
    ds_len = 40;
    send_image(1, 100, N);
    wait_done(1'b1, b_done);
    check_image("t2", 1, b_got);
    check("t2 stable stall", stall_err - b_stall, 0);
    check("t2 done pulses", done_cnt - b_done, 1);

    // 3: input gaps at 30% duty
    snap();
    send_image(2, 30, N);
    wait_done(1'b0, b_done);
    check("t3 writes", wr_total - b_wr, N);
    check("t3 start after last", start_cyc - last_wr_cyc, 1);
    check("t3 starts", start_cnt - b_start, 1);
    check_image("t3", 2, b_got);

    // 4: stale ready held across START
    snap();
    ds_drop = 3; ds_len = 20;
    send_image(3, 100, N);
    wait_done(1'b0, b_done);
    check("t4 rise after drop", rise_cyc > start_cyc + 5, 1);
    check("t4 first valid lat", first_v_cyc - rise_cyc, 3);
    check_image("t4", 3, b_got);
    ds_drop = 0;

    // 5: reset in the middle of LOAD
    snap();
    send_image(4, 100, 400);
    reset = 1'b1;
    #1;
    check("t5 busy", busy, 0);
    check("t5 s_ready", bus.s_ready, 0);
    check("t5 bram_en", bus.bram_en, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("t5 no start", start_cnt - b_start, 0);
    snap();
    send_image(5, 100, N);
    wait_done(1'b0, b_done);
    check_image("t5", 5, b_got);

    // 6: reset in the middle of DRAIN
    snap();
    send_image(6, 100, N);
    for (int n = 0; n < 3000 && got_q.size() < b_got + 300; n++) tick();
    check("t6 reached 300", got_q.size() >= b_got + 300, 1);
    reset = 1'b1;
    #1;
    check("t6 m_valid", bus.m_valid, 0);
    check("t6 busy", busy, 0);
    check("t6 img_done", img_done, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("t6 no done", done_cnt - b_done, 0);
    snap();
    send_image(7, 100, N);
    wait_done(1'b1, b_done);
    check_image("t6", 7, b_got);

`ifdef DSKW_TIMEOUT_EN
    // 7: watchdog with Deskew stuck busy
    snap();
    ds_len = 1_000_000;
    send_image(8, 100, N);
    for (int n = 0; n < 200 && busy; n++) tick();
    check("t7 timeout_err", timeout_err, 1);
    check("t7 idle", busy, 0);
    check("t7 err timing", err_cyc - start_cyc, 51);
    check("t7 no m_valid", valid_cyc - b_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
